// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register in front of the ALU. Captures the decoded RV32I/M
//   fields and operands, selects ALU operands (with optional MEM/WB bypass),
//   owns the architectural flags register and interlocks load-use hazards.
//
//   Build option:
//     ID_EX_FWD_EN  defined   -> MEM/WB bypass on captured sources, plus a
//                                stall while a source waits on a load in MEM.
//                   undefined -> no bypass; ID is held while any source is
//                                still being written by EX, MEM or WB.
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     id_valid / id_ready         decoder handshake
//     id_*                        decoded fields, regfile data, imm, pc, ctrl
//     flush                       kill the instruction held in EX
//     ex_ready                    downstream accepts the EX instruction
//     mem_* / wb_*                later-stage writeback info for hazards/bypass
//     alu_flags                   ALU flags_out, reloaded into the flags reg
//     ex_valid, ex_a, ex_b        live EX instruction and ALU operands
//     ex_opcode/funct3/funct7     ALU control
//     ex_rd/reg_write/is_load     carried downstream
//     ex_store_data               rs2 value for stores
//     ex_flags                    flags register -> ALU flags_in
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int FLAGS_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [6:0]         id_opcode,
  input  logic [2:0]         id_funct3,
  input  logic [6:0]         id_funct7,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_pc,
  input  logic               id_use_imm,
  input  logic               id_use_pc,
  input  logic               id_is_load,
  input  logic               id_reg_write,
  input  logic               flush,
  input  logic               ex_ready,
  input  logic               mem_reg_write,
  input  logic               mem_is_load,
  input  logic [REG_AW-1:0]  mem_rd,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [6:0]         ex_opcode,
  output logic [2:0]         ex_funct3,
  output logic [6:0]         ex_funct7,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_is_load,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [FLAGS_W-1:0] ex_flags
);

  // captured EX state
  logic               r_ex_valid;
  logic [6:0]         r_opcode;
  logic [2:0]         r_funct3;
  logic [6:0]         r_funct7;
  logic [REG_AW-1:0]  r_rs1;
  logic [REG_AW-1:0]  r_rs2;
  logic [REG_AW-1:0]  r_rd;
  logic [XLEN-1:0]    r_rs1_data;
  logic [XLEN-1:0]    r_rs2_data;
  logic [XLEN-1:0]    r_imm;
  logic [XLEN-1:0]    r_pc;
  logic               r_use_imm;
  logic               r_use_pc;
  logic               r_is_load;
  logic               r_reg_write;
  logic [FLAGS_W-1:0] r_flags;

  logic               w_fwd_stall;
  logic               w_raw_hold;
  logic               w_ex_valid;
  logic               w_ex_fire;
  logic               w_load_use;
  logic               w_id_ready;
  logic               w_capture;
  logic [XLEN-1:0]    w_rs1_val;
  logic [XLEN-1:0]    w_rs2_val;

`ifdef ID_EX_FWD_EN
  // MEM beats WB; a load in MEM has no result yet, so it is never a source.
  function automatic logic [XLEN-1:0] fwd_src(input logic [REG_AW-1:0] idx,
                                               input logic [XLEN-1:0]   cap);
    if (idx == '0)
      return '0;
    else if (mem_reg_write && !mem_is_load && (mem_rd == idx))
      return mem_result;
    else if (wb_reg_write && (wb_rd == idx))
      return wb_data;
    else
      return cap;
  endfunction

  assign w_rs1_val   = fwd_src(r_rs1, r_rs1_data);
  assign w_rs2_val   = fwd_src(r_rs2, r_rs2_data);
  // load data not yet available: present EX as empty until it reaches WB
  assign w_fwd_stall = mem_is_load && mem_reg_write && (mem_rd != '0) &&
                       ((r_rs1 == mem_rd) || (r_rs2 == mem_rd));
  assign w_raw_hold  = 1'b0;
`else
  // No bypass: keep the instruction in ID until every pending writer of its
  // sources has retired, so the regfile read is already current.
  function automatic logic src_busy(input logic [REG_AW-1:0] idx);
    return (idx != '0) &&
           ((r_ex_valid && r_reg_write && (r_rd == idx)) ||
            (mem_reg_write && (mem_rd == idx)) ||
            (wb_reg_write && (wb_rd == idx)));
  endfunction

  assign w_rs1_val   = r_rs1_data;
  assign w_rs2_val   = r_rs2_data;
  assign w_fwd_stall = 1'b0;
  assign w_raw_hold  = src_busy(id_rs1) || src_busy(id_rs2);

  logic w_unused;
  assign w_unused = ^{mem_is_load, mem_result, wb_data, r_rs1, r_rs2};
`endif

  assign w_ex_valid = r_ex_valid & ~w_fwd_stall;
  assign w_ex_fire  = w_ex_valid & ex_ready;
  assign w_load_use = r_ex_valid && r_is_load && (r_rd != '0) &&
                      ((r_rd == id_rs1) || (r_rd == id_rs2));
  assign w_id_ready = ~rst & (~r_ex_valid | w_ex_fire) & ~w_load_use & ~w_raw_hold;
  // id_ready may be high during flush; the instruction is not taken then
  assign w_capture  = id_valid & w_id_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_use_imm   <= 1'b0;
      r_use_pc    <= 1'b0;
      r_is_load   <= 1'b0;
      r_reg_write <= 1'b0;
      r_flags     <= '0;
    end else begin
      if (w_ex_fire && !flush)
        r_flags <= alu_flags;

      if (flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_capture) begin
        r_ex_valid  <= 1'b1;
        r_opcode    <= id_opcode;
        r_funct3    <= id_funct3;
        r_funct7    <= id_funct7;
        r_rs1       <= id_rs1;
        r_rs2       <= id_rs2;
        r_rd        <= id_rd;
        r_rs1_data  <= id_rs1_data;
        r_rs2_data  <= id_rs2_data;
        r_imm       <= id_imm;
        r_pc        <= id_pc;
        r_use_imm   <= id_use_imm;
        r_use_pc    <= id_use_pc;
        r_is_load   <= id_is_load;
        r_reg_write <= id_reg_write;
      end else if (w_ex_fire) begin
        // fired with nothing behind it: becomes a bubble
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign id_ready      = w_id_ready;
  assign ex_valid      = w_ex_valid;
  assign ex_a          = r_use_pc  ? r_pc  : w_rs1_val;
  assign ex_b          = r_use_imm ? r_imm : w_rs2_val;
  assign ex_store_data = w_rs2_val;
  assign ex_opcode     = r_opcode;
  assign ex_funct3     = r_funct3;
  assign ex_funct7     = r_funct7;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_is_load    = r_is_load;
  assign ex_flags      = r_flags;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, operand select, hazards,
// stall hold, flag reload, flush and reset while stalled.
module tb_id_ex_stage;
  localparam int XLEN = 32, REG_AW = 5, FLAGS_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_ready;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic id_use_imm, id_use_pc, id_is_load, id_reg_write;
  logic flush, ex_ready;
  logic mem_reg_write, mem_is_load;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic [XLEN-1:0] mem_result, wb_data;
  logic wb_reg_write;
  logic [FLAGS_W-1:0] alu_flags, ex_flags;
  logic ex_valid;
  logic [XLEN-1:0] ex_a, ex_b, ex_store_data;
  logic [6:0] ex_opcode, ex_funct7;
  logic [2:0] ex_funct3;
  logic [REG_AW-1:0] ex_rd;
  logic ex_reg_write, ex_is_load;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .FLAGS_W(FLAGS_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_is_load(id_is_load), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_flags(alu_flags),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_store_data(ex_store_data), .ex_flags(ex_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pipe();
    mem_reg_write = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [REG_AW-1:0] rs1,
                        input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1; id_opcode = op; id_funct3 = 0; id_funct7 = 0;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = 0; id_pc = 0;
    id_use_imm = 0; id_use_pc = 0; id_is_load = 0; id_reg_write = 1;
  endtask

  initial begin
    rst = 1; flush = 0; ex_ready = 1; alu_flags = 0;
    set_id(7'h00, 0, 0, 0, 0, 0);
    id_valid = 0; id_reg_write = 0;
    clr_pipe();

    // reset, two cycles
    tick(); tick();
    chk("rst_ex_valid", {31'b0, ex_valid}, 0);
    chk("rst_flags", {24'b0, ex_flags}, 0);
    chk("rst_id_ready", {31'b0, id_ready}, 0);
    rst = 0; #1;
    chk("post_rst_id_ready", {31'b0, id_ready}, 1);

    // ADD x3,x1,x2 with 5,7
    set_id(7'h33, 1, 2, 3, 5, 7);
    tick();
    id_valid = 0; #1;
    chk("add_valid", {31'b0, ex_valid}, 1);
    chk("add_a", ex_a, 5);
    chk("add_b", ex_b, 7);
    chk("add_op", {25'b0, ex_opcode}, 32'h33);
    chk("add_rd", {27'b0, ex_rd}, 3);
    chk("add_st", ex_store_data, 7);
    tick();
    chk("add_drain", {31'b0, ex_valid}, 0);

    // AUIPC-style: a := pc, b := imm, store data stays rs2
    set_id(7'h17, 0, 0, 6, 32'hdead, 9);
    id_use_pc = 1; id_use_imm = 1; id_pc = 32'h40; id_imm = 32'h1000;
    tick();
    id_valid = 0; #1;
    chk("auipc_a", ex_a, 32'h40);
    chk("auipc_b", ex_b, 32'h1000);
    chk("auipc_st", ex_store_data, 9);
    tick();

`ifdef ID_EX_FWD_EN
    // hold ADD x1,x2 in EX and vary the bypass sources
    ex_ready = 0;
    set_id(7'h33, 1, 2, 3, 5, 7);
    tick();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 1; mem_result = 32'h10;
    wb_reg_write = 1; wb_rd = 1; wb_data = 32'h20; #1;
    chk("fwd_mem_wins", ex_a, 32'h10);
    mem_reg_write = 0; #1;
    chk("fwd_wb", ex_a, 32'h20);
    clr_pipe();
    mem_reg_write = 1; mem_is_load = 1; mem_rd = 2; #1;
    chk("fwd_stall", {31'b0, ex_valid}, 0);
    clr_pipe(); #1;
    chk("fwd_stall_clr", {31'b0, ex_valid}, 1);
    ex_ready = 1;
    tick();
    // x0 source always reads zero
    set_id(7'h33, 0, 0, 3, 32'h55, 0);
    tick();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h77; #1;
    chk("fwd_x0", ex_a, 0);
    tick();
    clr_pipe();
`else
    // no bypass: pending writers of a source hold ID
    id_rs1 = 1; id_rs2 = 0;
    mem_reg_write = 1; mem_rd = 1; #1;
    chk("raw_mem", {31'b0, id_ready}, 0);
    mem_reg_write = 0; wb_reg_write = 1; wb_rd = 1; #1;
    chk("raw_wb", {31'b0, id_ready}, 0);
    clr_pipe(); id_rs1 = 0;
    mem_reg_write = 1; mem_rd = 0; #1;
    chk("raw_x0", {31'b0, id_ready}, 1);
    clr_pipe();
`endif

    // load-use: LW x4 then ADD x5,x4,x4
    set_id(7'h03, 1, 0, 4, 32'h100, 0);
    id_is_load = 1; id_use_imm = 1; id_imm = 8; id_funct3 = 3'd2;
    tick();
    set_id(7'h33, 4, 4, 5, 0, 0); #1;
    chk("lu_ready", {31'b0, id_ready}, 0);
    chk("lu_ld_valid", {31'b0, ex_valid}, 1);
    chk("lu_ld_a", ex_a, 32'h100);
    chk("lu_ld_isld", {31'b0, ex_is_load}, 1);
    tick();
    mem_reg_write = 1; mem_is_load = 1; mem_rd = 4; #1;
    chk("lu_bubble", {31'b0, ex_valid}, 0);
`ifdef ID_EX_FWD_EN
    chk("lu_take", {31'b0, id_ready}, 1);
    tick();
    id_valid = 0; clr_pipe();
    wb_reg_write = 1; wb_rd = 4; wb_data = 32'h44; #1;
    chk("lu_add_valid", {31'b0, ex_valid}, 1);
    chk("lu_add_a", ex_a, 32'h44);
    chk("lu_add_b", ex_b, 32'h44);
    tick();
    clr_pipe();
`else
    chk("lu_hold_mem", {31'b0, id_ready}, 0);
    tick();
    clr_pipe();
    wb_reg_write = 1; wb_rd = 4; wb_data = 32'h44; #1;
    chk("lu_hold_wb", {31'b0, id_ready}, 0);
    tick();
    clr_pipe(); id_rs1_data = 32'h44; id_rs2_data = 32'h44; #1;
    chk("lu_take", {31'b0, id_ready}, 1);
    tick();
    id_valid = 0; #1;
    chk("lu_add_valid", {31'b0, ex_valid}, 1);
    chk("lu_add_a", ex_a, 32'h44);
    chk("lu_add_b", ex_b, 32'h44);
    chk("lu_add_rd", {27'b0, ex_rd}, 5);
    tick();
`endif

    // stall 3 cycles: fields held, flags untouched
    set_id(7'h33, 1, 2, 7, 32'h11, 32'h22);
    id_funct7 = 7'h20;
    ex_ready = 0;
    tick();
    set_id(7'h13, 0, 0, 9, 32'h99, 32'h99);
    alu_flags = 8'h02;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_a", ex_a, 32'h11);
      chk("stall_f7", {25'b0, ex_funct7}, 32'h20);
      chk("stall_flags", {24'b0, ex_flags}, 0);
      chk("stall_ready", {31'b0, id_ready}, 0);
      tick();
    end
    id_valid = 0; ex_ready = 1;
    tick();
    chk("fire_flags", {24'b0, ex_flags}, 32'h02);
    chk("fire_empty", {31'b0, ex_valid}, 0);

    // flush wins over fire and capture
    set_id(7'h33, 1, 2, 3, 1, 2);
    tick();
    set_id(7'h33, 0, 0, 8, 3, 4);
    flush = 1; alu_flags = 8'h0F; #1;
    chk("flush_ready", {31'b0, id_ready}, 1);
    tick();
    flush = 0; id_valid = 0; #1;
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_flags", {24'b0, ex_flags}, 32'h02);

    // reset while stalled discards the instruction
    set_id(7'h33, 1, 2, 3, 32'hAB, 2);
    ex_ready = 0;
    tick();
    id_valid = 0; rst = 1;
    tick();
    rst = 0; ex_ready = 1; #1;
    chk("rst_mid_valid", {31'b0, ex_valid}, 0);
    chk("rst_mid_a", ex_a, 0);
    chk("rst_mid_flags", {24'b0, ex_flags}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
